compound_accumulator: RTL

COMPOUND_ACCUMULATOR -- requirements
Module: compound_accumulator

---
 rtl/compound_accumulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/compound_accumulator.sv
// Accumulator with compound-assignment opcodes; multiply is an iterative
// shift-add over WIDTH cycles, all other ops complete in the accept cycle.
module compound_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic             err,
  output logic [1:0]       dbg_state
);

  // Handshake: a command transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready. Neither
  // valid may depend combinationally on the corresponding ready.

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [WIDTH-1:0]   prod;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   alu;
  logic               illegal;
  logic               big_shift;
  logic [WIDTH-1:0]   prod_next;
  logic               mul_last;

  assign acc_out   = acc;
  assign dbg_state = state;

  // Shift amounts at or beyond the width saturate rather than wrap.
  assign big_shift = (32'(operand) >= 32'(WIDTH));
  assign prod_next = prod + (mul_b[0] ? mul_a : '0);
  assign mul_last  = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    alu     = acc;
    illegal = 1'b0;
    case (op)
      4'd0:  alu = acc + operand;
      4'd1:  alu = acc - operand;
      4'd3:  alu = acc & operand;
      4'd4:  alu = acc | operand;
      4'd5:  alu = acc ^ operand;
      4'd6:  alu = big_shift ? '0 : (acc << operand);
      4'd7:  alu = big_shift ? '0 : (acc >> operand);
      4'd8:  alu = big_shift ? '0 : (acc <<< operand);
      4'd9:  alu = big_shift ? {WIDTH{acc[WIDTH-1]}}
                             : $unsigned($signed(acc) >>> operand);
      4'd10: alu = operand;
      4'd2:  alu = acc;
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (op == 4'd2) begin
              state <= MUL;
              mul_a <= acc;
              mul_b <= operand;
              prod  <= '0;
              cnt   <= '0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              err       <= illegal;
              if (!illegal) acc <= alu;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        MUL: begin
          prod  <= prod_next;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + 1'b1;
          if (mul_last) begin
            acc       <= prod_next;
            state     <= DONE;
            out_valid <= 1'b1;
            err       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          err       <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
